toggle_activity_monitor: RTL and testbench

TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

---
 rtl/toggle_mon_pkg.sv | 16 +
 rtl/toggle_counter.sv | 44 ++++
 rtl/toggle_activity_monitor.sv | 134 +++++++++++++
 tb/tb_toggle_activity_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_mon_pkg.sv
// toggle_mon_pkg: shared types and default sizing for the toggle activity monitor.
// Holds the controller state encoding and the default parameter values
// (observed vector width, per-bit counter width, window-length width).
package toggle_mon_pkg;

  localparam int DEF_NUM_BITS = 3;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_WIN_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/toggle_counter.sv
// toggle_counter: one per-bit toggle counter of the activity monitor.
// Ports: clk/rst (async active-high), clr (synchronous clear, wins over en),
// en + tgl (count one toggle), cnt (registered count), cnt_nxt (value cnt takes next edge).
// Optional macro TOGGLE_MON_SAT_EN: saturate at all-ones instead of wrapping.
module toggle_counter
  import toggle_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             tgl,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  // cnt_nxt is exported so the parent can register a total that is
  // consistent with the counters on the very edge they update.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && tgl) begin
`ifdef TOGGLE_MON_SAT_EN
      if (cnt != {CNT_W{1'b1}}) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
`else
      cnt_nxt = cnt + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor: counts per-bit toggles of an observed vector over a
// window of accepted samples, then presents the counts and their sum for handshake.
// Ports: clk, rst (async active-high); start/abort/cont/win_len control;
// in_valid/in_ready/obs_bits sample input; res_valid/res_ready/res_toggles/res_total
// result output; busy = not idle. Optional macro TOGGLE_MON_SAT_EN: saturating counters.
module toggle_activity_monitor
  import toggle_mon_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_W    = DEF_WIN_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 cont,
  input  logic [WIN_W-1:0]                     win_len,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_BITS-1:0]                  obs_bits,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [NUM_BITS*CNT_W-1:0]            res_toggles,
  output logic [CNT_W+$clog2(NUM_BITS):0]      res_total,
  output logic                                 busy
);

  localparam int TOT_W = CNT_W + $clog2(NUM_BITS) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_BITS-1:0] prev;
  logic                first;
  logic [WIN_W-1:0]    samp_cnt;
  logic [WIN_W-1:0]    win_lat;
  logic [WIN_W-1:0]    samp_inc;
  logic [TOT_W-1:0]    total_q;
  logic [TOT_W-1:0]    total_nxt;
  logic [CNT_W-1:0]    cnt_q [NUM_BITS];
  logic [CNT_W-1:0]    cnt_d [NUM_BITS];

  logic start_acc;
  logic accept;
  logic last;
  logic res_hs;
  logic cnt_clr;
  logic cnt_en;

  // abort overrides everything: it blocks start, sample acceptance and the
  // result handshake in the same cycle.
  assign start_acc = (state == ST_IDLE) && start && !abort;
  assign accept    = (state == ST_COUNT) && in_valid && !abort;
  assign samp_inc  = samp_cnt + WIN_W'(1);
  assign last      = accept && (samp_inc == win_lat);
  assign res_hs    = (state == ST_REPORT) && res_ready && !abort;
  assign cnt_clr   = start_acc || (res_hs && cont);
  // The first sample of a measurement only seeds prev.
  assign cnt_en    = accept && !first;

  assign in_ready  = (state == ST_COUNT);
  assign res_valid = (state == ST_REPORT);
  assign busy      = (state != ST_IDLE);
  assign res_total = total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_acc) state_nxt = ST_COUNT;
      ST_COUNT:  if (last)      state_nxt = ST_REPORT;
      ST_REPORT: if (res_hs)    state_nxt = cont ? ST_COUNT : ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      first    <= 1'b1;
      samp_cnt <= '0;
      win_lat  <= '0;
      total_q  <= '0;
    end else begin
      total_q <= total_nxt;
      if (start_acc) begin
        win_lat  <= (win_len == '0) ? WIN_W'(1) : win_len;
        samp_cnt <= '0;
        first    <= 1'b1;
      end else if (res_hs && cont) begin
        // Continuous restart keeps prev so the boundary toggle is counted.
        samp_cnt <= '0;
        first    <= 1'b0;
      end else if (accept) begin
        samp_cnt <= samp_inc;
        prev     <= obs_bits;
        first    <= 1'b0;
      end
    end
  end

  // Summing the counters' next values makes total_q track the counters
  // edge for edge, so it is already correct when res_valid rises.
  always_comb begin
    total_nxt = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      total_nxt = total_nxt + TOT_W'(cnt_d[i]);
    end
  end

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    toggle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .tgl     (prev[i] ^ obs_bits[i]),
      .cnt     (cnt_q[i]),
      .cnt_nxt (cnt_d[i])
    );
    assign res_toggles[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb_toggle_activity_monitor: scoreboard bench for toggle_activity_monitor.
// The driver keeps a plain-arithmetic model of window toggle counts and queues
// the expected result; a monitor pops and compares at every result handshake.
module tb_toggle_activity_monitor;

  localparam int NB = 3;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int TW = CW + $clog2(NB) + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             cont;
  logic [WW-1:0]    win_len;
  logic             in_valid;
  logic             in_ready;
  logic [NB-1:0]    obs_bits;
  logic             res_valid;
  logic             res_ready;
  logic [NB*CW-1:0] res_toggles;
  logic [TW-1:0]    res_total;
  logic             busy;

  toggle_activity_monitor #(.NUM_BITS(NB), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cont        (cont),
    .win_len     (win_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .obs_bits    (obs_bits),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_toggles (res_toggles),
    .res_total   (res_total),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB*CW-1:0] t;
    logic [TW-1:0]    total;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int            m_cnt [NB];
  logic [NB-1:0] m_prev;
  bit            m_first;
  int            m_n;
  int            m_win;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    m_n = 0;
  endtask

  task automatic model_sample(input logic [NB-1:0] v);
    exp_t e;
    int   tot;
    if (!m_first) begin
      for (int i = 0; i < NB; i++) begin
        if (m_prev[i] != v[i]) begin
`ifdef TOGGLE_MON_SAT_EN
          if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
`else
          m_cnt[i] = (m_cnt[i] + 1) % (CMAX + 1);
`endif
        end
      end
    end
    m_prev  = v;
    m_first = 1'b0;
    m_n     = m_n + 1;
    if (m_n == m_win) begin
      tot = 0;
      e   = '0;
      for (int i = 0; i < NB; i++) begin
        e.t[i*CW +: CW] = CW'(m_cnt[i]);
        tot = tot + m_cnt[i];
      end
      e.total = TW'(tot);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int w);
    win_len = WW'(w);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    m_win   = (w == 0) ? 1 : w;
    m_first = 1'b1;
    model_clear();
    chk("busy_after_start", busy, 1);
  endtask

  task automatic feed(input logic [NB-1:0] v, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      obs_bits = NB'($urandom);
      tick();
    end
    in_valid = 1'b1;
    obs_bits = v;
    chk("in_ready_count", in_ready, 1);
    tick();
    in_valid = 1'b0;
    model_sample(v);
  endtask

  task automatic report(input int stall, input bit c);
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      in_valid  = 1'b1;
      obs_bits  = NB'($urandom);
      chk("in_ready_report", in_ready, 0);
      chk("res_valid_hold", res_valid, 1);
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    cont      = c;
    chk("res_valid_report", res_valid, 1);
    tick();
    res_ready = 1'b0;
    cont      = 1'b0;
    if (c) model_clear();
  endtask

  // Scoreboard monitor: compares at each completed result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int i = 0; i < NB; i++) begin
          chk($sformatf("res_toggles[%0d]", i), res_toggles[i*CW +: CW], e.t[i*CW +: CW]);
        end
        chk("res_total", res_total, e.total);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    win_len = '0; in_valid = 1'b0; obs_bits = '0; res_ready = 1'b0;
    m_prev = '0; m_first = 1'b1; m_n = 0; m_win = 1;
    model_clear();

    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_total", res_total, 0);
    chk("rst_res_toggles", res_toggles, 0);
    tick();
    rst = 1'b0;
    tick();

    // Four-sample window, then a continuous window crossing the boundary,
    // then a long stall in REPORT with valid samples offered.
    do_start(4);
    feed(3'b010, 0);
    feed(3'b011, 1);
    feed(3'b110, 0);
    feed(3'b111, 2);
    report(0, 1'b1);
    for (int k = 0; k < 4; k++) feed(3'b110, k % 2);
    report(10, 1'b0);
    chk("idle_after_report", busy, 0);

    // Abort after 2 of 4 samples; the sample offered with abort is dropped.
    do_start(4);
    feed(3'b000, 0);
    feed(3'b111, 0);
    abort = 1'b1; in_valid = 1'b1; obs_bits = 3'b101;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_result", res_valid, 0);
      tick();
    end

    // win_len 0 behaves as a single-sample window.
    do_start(0);
    feed(3'b101, 0);
    chk("win0_report", res_valid, 1);
    report(1, 1'b0);

    // abort and start together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1; win_len = 8'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // start while counting is ignored (window stays 3).
    do_start(3);
    feed(3'b001, 0);
    start = 1'b1; win_len = 8'd1;
    tick();
    start = 1'b0;
    feed(3'b000, 0);
    chk("start_ignored", res_valid, 0);
    feed(3'b011, 0);
    report(0, 1'b0);

    // Abort while a result is pending drops it without handshake.
    do_start(2);
    feed(3'b100, 0);
    feed(3'b010, 0);
    res_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_report_valid", res_valid, 0);
    chk("abort_report_busy", busy, 0);

    // d0 alternating for 20 samples: wraps or saturates the 4-bit counter.
    do_start(20);
    for (int k = 0; k < 20; k++) feed((k % 2) ? 3'b001 : 3'b000, 0);
    report(0, 1'b0);

    // Reset mid-window clears outputs without a clock edge.
    do_start(5);
    feed(3'b000, 0);
    feed(3'b111, 0);
    feed(3'b000, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_toggles", res_toggles, 0);
    chk("midrst_res_total", res_total, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomized windows with continuous chains and stalls.
    for (int w = 0; w < 25; w++) begin
      int nwin;
      do_start($urandom_range(0, 6));
      nwin = $urandom_range(1, 3);
      for (int k = 0; k < nwin; k++) begin
        for (int s = 0; s < m_win; s++) feed(NB'($urandom), $urandom_range(0, 2));
        report($urandom_range(0, 3), (k != nwin - 1));
      end
    end

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
